// File: rtl/clock_disp_scan_pkg.sv
// Shared types and constants for the 6-digit time display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-high (common cathode).
package clock_disp_pkg;

  typedef enum logic {BLANK, SHOW} state_e;

  typedef struct packed {
    logic [3:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       pm;
  } time_snap_t;

  localparam int unsigned NUM_DIGITS = 6;

  localparam logic [2:0] IDX_HT = 3'd5;
  localparam logic [2:0] IDX_HO = 3'd4;
  localparam logic [2:0] IDX_MT = 3'd3;
  localparam logic [2:0] IDX_MO = 3'd2;
  localparam logic [2:0] IDX_ST = 3'd1;
  localparam logic [2:0] IDX_SO = 3'd0;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Tens/ones of a 0..59 value by compare-subtract; returns {tens, ones}.
  function automatic logic [7:0] split10(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = '0;
    if (r >= 6'd50)      begin t = 4'd5; r = r - 6'd50; end
    else if (r >= 6'd40) begin t = 4'd4; r = r - 6'd40; end
    else if (r >= 6'd30) begin t = 4'd3; r = r - 6'd30; end
    else if (r >= 6'd20) begin t = 4'd2; r = r - 6'd20; end
    else if (r >= 6'd10) begin t = 4'd1; r = r - 6'd10; end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/clock_disp_scan_if.sv
// Time inputs from the timekeeping core and multiplexed display outputs.
interface clock_disp_scan_if;
  logic       ena;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       am_pm;
  logic       sec_tick;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_en;

  modport master (
    output ena, hours, minutes, seconds, am_pm, sec_tick,
    input  seg, dp, dig_en
  );

  modport slave (
    input  ena, hours, minutes, seconds, am_pm, sec_tick,
    output seg, dp, dig_en
  );
endinterface

// File: rtl/clock_disp_scan_seg7_encode.sv
// Digit code (0-9, 10=dash, 11=blank) to 7-segment pattern.
module seg7_encode
  import clock_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:      seg_o = SEG_0;
      4'd1:      seg_o = SEG_1;
      4'd2:      seg_o = SEG_2;
      4'd3:      seg_o = SEG_3;
      4'd4:      seg_o = SEG_4;
      4'd5:      seg_o = SEG_5;
      4'd6:      seg_o = SEG_6;
      4'd7:      seg_o = SEG_7;
      4'd8:      seg_o = SEG_8;
      4'd9:      seg_o = SEG_9;
      CODE_DASH: seg_o = SEG_DASH;
      default:   seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/clock_disp_scan.sv
// 6-digit multiplexed 7-segment scanner with SHOW/BLANK anti-ghosting gap,
// per-frame snapshot of the time inputs and seconds-driven blinking colon.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 10000,
  parameter int unsigned BLANK_CYC = 100
) (
  input logic             clk,
  input logic             rst_n,
  clock_disp_scan_if.slave bus
);
  localparam int unsigned MAXC  = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam time_snap_t SNAP_RST = '{h: 4'd12, m: 6'd0, s: 6'd0, pm: 1'b0};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  time_snap_t       snap_q, snap_d;
  logic             colon_q, colon_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [5:0]       dig_q, dig_d;

  logic [3:0] code;
  logic [6:0] seg_enc;
  logic [7:0] m_split, s_split;
  logic       h_ok, m_ok, s_ok, dp_calc;

  // Digit content is decoded from idx_q while still in BLANK, since idx has
  // already advanced to the digit about to be shown.
  always_comb begin
    m_split = split10(snap_q.m);
    s_split = split10(snap_q.s);
    h_ok    = (snap_q.h >= 4'd1) && (snap_q.h <= 4'd12);
    m_ok    = (snap_q.m <= 6'd59);
    s_ok    = (snap_q.s <= 6'd59);
    code    = CODE_BLANK;
    case (idx_q)
      IDX_HT: code = !h_ok ? CODE_DASH : ((snap_q.h >= 4'd10) ? 4'd1 : CODE_BLANK);
      IDX_HO: code = !h_ok ? CODE_DASH : ((snap_q.h >= 4'd10) ? snap_q.h - 4'd10 : snap_q.h);
      IDX_MT: code = m_ok ? m_split[7:4] : CODE_DASH;
      IDX_MO: code = m_ok ? m_split[3:0] : CODE_DASH;
      IDX_ST: code = s_ok ? s_split[7:4] : CODE_DASH;
      IDX_SO: code = s_ok ? s_split[3:0] : CODE_DASH;
      default: code = CODE_BLANK;
    endcase
  end

  seg7_encode u_enc (
    .code_i (code),
    .seg_o  (seg_enc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    colon_d = colon_q ^ (bus.ena & bus.sec_tick);
    seg_d   = seg_q;
    dp_d    = dp_q;
    dig_d   = dig_q;
    dp_calc = (((idx_q == IDX_HO) || (idx_q == IDX_MO)) && colon_d) ||
              ((idx_q == IDX_SO) && snap_q.pm);
    if (!bus.ena) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = '0;
      seg_d   = '0;
      dp_d    = 1'b0;
      dig_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
            seg_d   = seg_enc;
            dp_d    = dp_calc;
            dig_d   = 6'(1) << idx_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_HT) ? IDX_SO : idx_q + 3'd1;
            seg_d   = '0;
            dp_d    = 1'b0;
            dig_d   = '0;
            if (idx_q == IDX_HT) begin
              snap_d = '{h: bus.hours, m: bus.minutes, s: bus.seconds, pm: bus.am_pm};
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= SNAP_RST;
      colon_q <= 1'b0;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      colon_q <= colon_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.dig_en = dig_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Scoreboard bench: a frame-timing reference model predicts every cycle's
// display outputs; a monitor pops and compares on the opposite clock edge.
module tb_clock_disp_scan;
  localparam int unsigned SD = 4;
  localparam int unsigned BC = 2;
  localparam int unsigned SLOT = SD + BC;
  localparam int unsigned FRAME = 6 * SLOT;

  logic clk;
  logic rst_n;
  clock_disp_scan_if bus ();

  clock_disp_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int prints = 0;
  bit done = 1'b0;
  logic [13:0] exp_q[$];

  function automatic logic [6:0] segof(input int d);
    logic [6:0] tab [12];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
            7'h40, 7'h00};
    return tab[d];
  endfunction

  // Expected {dig_en, seg, dp} while digit idx is lit.
  function automatic logic [13:0] exp_out(input int idx, input int h, input int m,
                                          input int s, input bit pm, input bit colon);
    int d[6];
    bit dp;
    if (h >= 1 && h <= 12) begin
      d[5] = (h >= 10) ? 1 : 11;
      d[4] = (h >= 10) ? h - 10 : h;
    end else begin
      d[5] = 10; d[4] = 10;
    end
    if (m <= 59) begin d[3] = m / 10; d[2] = m % 10; end else begin d[3] = 10; d[2] = 10; end
    if (s <= 59) begin d[1] = s / 10; d[0] = s % 10; end else begin d[1] = 10; d[0] = 10; end
    dp = ((idx == 4 || idx == 2) && colon) || (idx == 0 && pm);
    return {6'(1 << idx), segof(d[idx]), dp};
  endfunction

  // Reference model: position in the frame is derived from cycles since
  // the display (re)started.
  initial begin
    int t, p, sh, sm, ss;
    bit spm, colon;
    logic [13:0] cur;
    t = 0; sh = 12; sm = 0; ss = 0; spm = 0; colon = 0; cur = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0; sh = 12; sm = 0; ss = 0; spm = 0; colon = 0;
        exp_q.push_back('0);
      end else begin
        if (bus.ena && bus.sec_tick) colon = ~colon;
        if (!bus.ena) begin
          t = 0;
          exp_q.push_back('0);
        end else begin
          t++;
          p = t % FRAME;
          if (p == 0) begin
            sh = int'(bus.hours); sm = int'(bus.minutes);
            ss = int'(bus.seconds); spm = bus.am_pm;
          end
          if (p % SLOT == BC) cur = exp_out(p / SLOT, sh, sm, ss, spm, colon);
          exp_q.push_back((p % SLOT >= BC) ? cur : 14'd0);
        end
      end
    end
  end

  initial begin
    logic [13:0] e, a;
    forever begin
      @(negedge clk);
      if (done) break;
      a = {bus.dig_en, bus.seg, bus.dp};
      checks++;
      if (!$onehot0(bus.dig_en)) begin
        errors++;
        $display("FAIL onehot t=%0t dig_en=%b", $time, bus.dig_en);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got %h", $time, a);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          if (prints < 20) begin
            prints++;
            $display("FAIL scoreboard t=%0t got dig_en=%b seg=%h dp=%b, expected dig_en=%b seg=%h dp=%b",
                     $time, a[13:8], a[7:1], a[0], e[13:8], e[7:1], e[0]);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit pm);
    bus.hours = 4'(h); bus.minutes = 6'(m); bus.seconds = 6'(s); bus.am_pm = pm;
  endtask

  task automatic wait_dig(input logic [5:0] v, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bus.dig_en == v) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s timeout waiting dig_en=%b, last=%b", name, v, bus.dig_en);
    end
  endtask

  task automatic tick;
    bus.sec_tick = 1'b1; cyc(1); bus.sec_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.sec_tick = 1'b0;
    set_time(12, 0, 0, 0);
    cyc(3);
    #1;
    checks++;
    if ({bus.dig_en, bus.seg, bus.dp} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", {bus.dig_en, bus.seg, bus.dp});
    end
    @(negedge clk);
    rst_n = 1'b1; bus.ena = 1'b1;
    cyc(2 * FRAME);

    set_time(9, 7, 45, 1);
    cyc(2 * FRAME + 5);

    set_time(10, 15, 0, 0);
    cyc(2 * FRAME);
    wait_dig(6'b000100, "wait_idx2");
    set_time(10, 16, 0, 0);
    cyc(2 * FRAME);

    tick(); cyc(FRAME); tick(); cyc(FRAME);

    set_time(0, 60, 63, 0);
    cyc(2 * FRAME);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0)
        set_time($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63),
                 1'($urandom_range(0, 1)));
      bus.sec_tick = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        bus.ena = 1'b0;
        cyc($urandom_range(1, 10));
        bus.ena = 1'b1;
      end
      cyc(1);
    end
    bus.sec_tick = 1'b0;
    set_time(11, 59, 58, 1);
    cyc(FRAME);

    wait_dig(6'b001000, "wait_idx3");
    bus.ena = 1'b0;
    cyc(1);
    checks++;
    if (bus.dig_en !== 6'd0) begin
      errors++;
      $display("FAIL ena_off got dig_en=%b required 000000", bus.dig_en);
    end
    cyc(4);
    bus.ena = 1'b1;
    cyc(BC);
    checks++;
    if (bus.dig_en !== 6'b000001) begin
      errors++;
      $display("FAIL ena_restart got dig_en=%b required 000001", bus.dig_en);
    end
    cyc(FRAME);

    wait_dig(6'b010000, "wait_idx4");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dig_en, bus.seg, bus.dp} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got %h required 0", {bus.dig_en, bus.seg, bus.dp});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2 * FRAME);

    done = 1'b1;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
